// File: rtl/osd_trace_depacketization.sv
// osd_trace_depacketization: reassembles DII trace event packets into WIDTH-bit trace or overflow records
package osd_dii_pkg;
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;
endpackage

module osd_trace_depacketization
   import osd_dii_pkg::*;
#(
   parameter int WIDTH = 165
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      id,
   input  dii_flit          debug_in,
   output logic             debug_in_ready,
   output logic [WIDTH-1:0] trace_data,
   output logic             trace_overflow,
   output logic [15:0]      trace_src,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic             err
);
   localparam int NW = (WIDTH + 15) / 16;
   localparam int CW = $clog2(NW + 1);
   localparam logic [2:0] DEST = 3'd0, SRC = 3'd1, FLAGS = 3'd2, PAYLOAD = 3'd3, DROP = 3'd4, OUT = 3'd5;
   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d, last_idx;
   logic [WIDTH-1:0] data_q, data_d;
   logic [15:0]      src_q, src_d;
   logic             ovf_q, ovf_d, err_q, err_d, acc, known;
   assign acc            = debug_in.valid & debug_in_ready;
   assign known          = debug_in.data[15:14] == 2'b10 && (debug_in.data[13:10] == 4'd0 || debug_in.data[13:10] == 4'd5);
   assign last_idx       = ovf_q ? '0 : CW'(NW - 1);
   assign debug_in_ready = state_q != OUT;
   assign trace_valid    = state_q == OUT;
   assign trace_data     = data_q;
   assign trace_overflow = ovf_q;
   assign trace_src      = src_q;
   assign err            = err_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      src_d   = src_q;
      ovf_d   = ovf_q;
      err_d   = 1'b0;
      case (state_q)
         DEST: if (acc) begin
            state_d = debug_in.last ? DEST : (debug_in.data == id ? SRC : DROP);
            err_d   = debug_in.last || debug_in.data != id;
         end
         SRC: if (acc) begin
            src_d   = debug_in.data;
            state_d = debug_in.last ? DEST : FLAGS;
            err_d   = debug_in.last;
         end
         FLAGS: if (acc) begin
            state_d = debug_in.last ? DEST : (known ? PAYLOAD : DROP);
            err_d   = debug_in.last || !known;
            cnt_d   = '0;
            data_d  = '0;
            ovf_d   = debug_in.data[13:10] == 4'd5;
         end
         PAYLOAD: if (acc) begin
            // bits beyond WIDTH-1 in the final word simply have no destination
            for (int b = 0; b < WIDTH; b++)
               if (CW'(b / 16) == cnt_q) data_d[b] = debug_in.data[b % 16];
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == last_idx ? (debug_in.last ? OUT : DROP) : (debug_in.last ? DEST : PAYLOAD);
            err_d   = cnt_q == last_idx ? !debug_in.last : debug_in.last;
         end
         DROP: if (acc && debug_in.last) state_d = DEST;
         OUT: if (trace_ready) state_d = DEST;
         default: state_d = DEST;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= DEST;
         cnt_q   <= '0;
         data_q  <= '0;
         src_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         src_q   <= src_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: doc/osd_trace_depacketization.md
Name: osd_trace_depacketization

Overview:
- Receive end of the debug-interconnect trace event protocol: consumes DII event packets addressed to this module and reassembles each one into a WIDTH-bit trace record or an overflow notification.
- Presents the result on a valid/ready stream for host-side-in-fabric consumers: trace sinks, trace compressors, test benches.
- Counterpart of the trace packetizer used by the core trace modules.

Parameters:
- WIDTH, 165, trace record width in bits. Derived localparam NW = ceil(WIDTH/16) payload words per trace packet (11 at default).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low
- id  input  16  own DII address; packets with other dest are dropped
- debug_in  input  dii_flit (valid, last, data[15:0])  incoming flit
- debug_in_ready  output  1  flit accept
- trace_data  output  WIDTH  reassembled record
- trace_overflow  output  1  1 = record is an overflow notification
- trace_src  output  16  source address of the packet
- trace_valid  output  1  record available
- trace_ready  input  1  consumer accept
- err  output  1  one-cycle pulse on malformed or foreign packet

Behaviour:
- Flit accepted when debug_in.valid & debug_in_ready.
- Packet layout:
  - word0 = dest.
  - word1 = src.
  - word2 = flags: [15:14] TYPE, [13:10] TYPE_SUB, [9:0] ignored.
  - Payload follows.
- Accepted packet kinds (TYPE = 2'b10, EVENT):
  - TYPE_SUB 0 = trace. Exactly NW payload words, least significant word first. Word k fills trace_data[16k+15:16k]. Bits above WIDTH-1 in the last word are discarded.
  - TYPE_SUB 5 = overflow. Exactly 1 payload word holding the dropped-event count. Output: trace_overflow=1, trace_data[15:0]=count, all other bits 0.
- FSM states: DEST, SRC, FLAGS, PAYLOAD, DROP, OUT.
  - DEST: accept. Go to SRC if data==id, else DROP with err=1. Last set on the same flit -> DEST with err=1.
  - SRC: latch src, go to FLAGS. Last set -> DEST, err=1.
  - FLAGS:
    - Unknown TYPE/TYPE_SUB -> DROP (or DEST if last), err=1.
    - Known type with last set (no payload) -> DEST, err=1.
    - Otherwise clear word counter and assembly register, go to PAYLOAD.
  - PAYLOAD: store word at counter index, counter++.
    - Last on the expected final word -> OUT.
    - Last early (short packet) -> DEST, err=1, no record.
    - Expected final word without last (long packet) -> DROP, err=1, no record.
  - DROP: discard flits until a flit with last is accepted, then DEST. No further err pulse.
  - OUT: trace_valid=1. On trace_valid & trace_ready go to DEST.
- debug_in_ready = 1 in every state except OUT (0). Single-entry output, no overlap.
- Latency: trace_valid asserts the cycle after the final payload flit is accepted. Best-case throughput is one record per (3+NW+1) cycles.
- trace_data, trace_overflow and trace_src are stable while trace_valid & !trace_ready.
- err is registered, high for exactly one cycle per offending packet.
- Reset (rst==0 at posedge): state=DEST, counter=0, trace_valid=0, err=0, trace_data=0, trace_overflow=0, trace_src=0, debug_in_ready=1 the cycle after release.
- Reset mid-packet: the partial packet is abandoned. Remaining flits of that packet after reset are parsed as a new packet, so dest mismatch causes DROP and err.
- Word counter is 4 bits for the default NW; in general width = clog2(NW+1). It never wraps because the long-packet check precedes increment overflow.

Test Plan:
- Trace packet: id=0x0010, flits {0x0010, 0x0002, 0x8000, w0..w10 = 0x0000..0x000A}, trace_ready=1 -> one-cycle trace_valid. Result: trace_data[15:0]=0, [31:16]=1 … [164:160]=0x0A, trace_src=0x0002, trace_overflow=0, err=0.
- Overflow packet: {0x0010, 0x0005, 0x9400, 0x0007} -> trace_overflow=1, trace_data=7 (upper bits 0), trace_src=0x0005.
- Backpressure: trace_ready=0 for 10 cycles after the first record while a second packet is offered. Expect debug_in_ready=0 and outputs stable throughout. The second record appears after trace_ready is raised, and no flit is lost.
- Foreign dest: packet with dest=0x0011 (id=0x0010), 14 flits -> err pulses once on the first flit, all 14 flits are accepted, no trace_valid. The following valid packet decodes correctly.
- Short packet (last on payload word 5) -> err=1, no record. Long packet (12 payload words) -> err=1 at the 11th word, rest dropped, no record.
- Reset asserted mid-payload (after word 4), then released, then a complete valid packet is sent -> no partial record, trace_valid=0 during reset, and the new packet decodes correctly.
